// File: rtl/scalar_tuple_pkg.sv
// Shared types and helpers for the scalar-tuple sequencer: FSM state encoding,
// width clamping and width-to-mask conversion.
package scalar_tuple_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StEmit,
        StDone
    } state_e;

    localparam int unsigned MaskW = 32;

    // Mask with the low w bits set; saturates at MaskW bits.
    function automatic logic [MaskW-1:0] width_mask(input int unsigned w);
        if (w >= MaskW) begin
            return '1;
        end
        return (32'd1 << w) - 32'd1;
    endfunction

    function automatic int unsigned clamp_width(input int unsigned w, input int unsigned wmax);
        return (w > wmax) ? wmax : w;
    endfunction

endpackage

// File: rtl/scalar_tuple_tbl.sv
// Field table for the scalar-tuple sequencer: per-field width/value registers with
// masked writes, truncation detection and a "higher enabled field exists" vector.
module scalar_tuple_tbl #(
    parameter int unsigned NFIELDS = 10,
    parameter int unsigned WMAX    = 4,
    parameter int unsigned IDXW    = $clog2(NFIELDS),
    parameter int unsigned WW      = $clog2(WMAX + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               we_i,
    input  logic [IDXW-1:0]    idx_i,
    input  logic [WW-1:0]      width_i,
    input  logic [WMAX-1:0]    value_i,
    output logic               trunc_o,
    output logic [WW-1:0]      width_o [NFIELDS],
    output logic [WMAX-1:0]    value_o [NFIELDS],
    output logic [NFIELDS-1:0] higher_en_o
);
    import scalar_tuple_pkg::*;

    logic [WW-1:0]      width_q [NFIELDS];
    logic [WMAX-1:0]    value_q [NFIELDS];
    logic [WW-1:0]      wr_width;
    logic [WMAX-1:0]    wr_mask;
    logic [WMAX-1:0]    wr_value;
    logic [NFIELDS-1:0] en;

    always_comb begin
        wr_width = WW'(clamp_width(32'(width_i), WMAX));
        wr_mask  = WMAX'(width_mask(32'(wr_width)));
        wr_value = value_i & wr_mask;
        // A disabled entry carries no value, so dropping its bits is not a truncation.
        trunc_o  = (wr_width != '0) && (|(value_i & ~wr_mask));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NFIELDS); i++) begin
                width_q[i] <= '0;
                value_q[i] <= '0;
            end
        end else if (we_i) begin
            width_q[idx_i] <= wr_width;
            value_q[idx_i] <= wr_value;
        end
    end

    always_comb begin
        en          = '0;
        higher_en_o = '0;
        for (int i = 0; i < int'(NFIELDS); i++) begin
            en[i] = (width_q[i] != '0);
        end
        for (int i = 0; i < int'(NFIELDS); i++) begin
            higher_en_o[i] = |(en >> (i + 1));
        end
    end

    assign width_o = width_q;
    assign value_o = value_q;

endmodule

// File: rtl/scalar_tuple_seq.sv
// Scalar-tuple sequencer: runtime-loadable table of variable-width fields streamed
// in index order over a valid/ready handshake, skipping width-0 (disabled) fields.
module scalar_tuple_seq #(
    parameter int unsigned NFIELDS = 10,
    parameter int unsigned WMAX    = 4,
    parameter int unsigned IDXW    = $clog2(NFIELDS),
    parameter int unsigned WW      = $clog2(WMAX + 1)
) (
    input  logic            clock_i,
    input  logic            reset_ni,
    input  logic            cfg_we_i,
    input  logic [IDXW-1:0] cfg_idx_i,
    input  logic [WW-1:0]   cfg_width_i,
    input  logic [WMAX-1:0] cfg_value_i,
    input  logic            start_i,
    output logic            busy_o,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [IDXW-1:0] out_idx_o,
    output logic [WW-1:0]   out_width_o,
    output logic [WMAX-1:0] out_data_o,
    output logic            out_last_o,
    output logic            done_o,
    output logic            err_trunc_o,
    output logic            err_cfg_o
);
    import scalar_tuple_pkg::*;

    localparam logic [IDXW-1:0] LastIdx = IDXW'(NFIELDS - 1);

    state_e             state_q, state_d;
    logic [IDXW-1:0]    idx_q, idx_d;
    logic [WW-1:0]      ow_q, ow_d;
    logic [WMAX-1:0]    od_q, od_d;
    logic               err_trunc_q, err_trunc_d;
    logic               err_cfg_q, err_cfg_d;

    logic [WW-1:0]      tbl_width [NFIELDS];
    logic [WMAX-1:0]    tbl_value [NFIELDS];
    logic [NFIELDS-1:0] higher_en;
    logic               tbl_trunc;
    logic               idx_in_range;
    logic               wr_legal;
    logic               emit;
    logic               cur_last;

    assign idx_in_range = (32'(cfg_idx_i) < NFIELDS);
    assign wr_legal     = cfg_we_i && (state_q == StIdle) && idx_in_range;

    scalar_tuple_tbl #(
        .NFIELDS (NFIELDS),
        .WMAX    (WMAX),
        .IDXW    (IDXW),
        .WW      (WW)
    ) u_tbl (
        .clk_i       (clock_i),
        .rst_ni      (reset_ni),
        .we_i        (wr_legal),
        .idx_i       (cfg_idx_i),
        .width_i     (cfg_width_i),
        .value_i     (cfg_value_i),
        .trunc_o     (tbl_trunc),
        .width_o     (tbl_width),
        .value_o     (tbl_value),
        .higher_en_o (higher_en)
    );

    assign emit     = (state_q == StEmit);
    assign cur_last = !higher_en[idx_q];

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ow_d        = ow_q;
        od_d        = od_q;
        err_trunc_d = err_trunc_q | (wr_legal & tbl_trunc);
        err_cfg_d   = err_cfg_q | (cfg_we_i & ~wr_legal);

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StScan;
                    idx_d   = '0;
                end
            end
            StScan: begin
                if (tbl_width[idx_q] != '0) begin
                    state_d = StEmit;
                    ow_d    = tbl_width[idx_q];
                    od_d    = tbl_value[idx_q];
                end else if (idx_q == LastIdx) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StEmit: begin
                if (out_ready_i) begin
                    if (cur_last) begin
                        state_d = StDone;
                    end else begin
                        state_d = StScan;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            ow_q        <= '0;
            od_q        <= '0;
            err_trunc_q <= 1'b0;
            err_cfg_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ow_q        <= ow_d;
            od_q        <= od_d;
            err_trunc_q <= err_trunc_d;
            err_cfg_q   <= err_cfg_d;
        end
    end

    // Presentation fields are forced to zero whenever no field is being offered.
    assign busy_o      = (state_q != StIdle);
    assign out_valid_o = emit;
    assign out_idx_o   = emit ? idx_q : '0;
    assign out_width_o = emit ? ow_q : '0;
    assign out_data_o  = emit ? od_q : '0;
    assign out_last_o  = emit & cur_last;
    assign done_o      = (state_q == StDone);
    assign err_trunc_o = err_trunc_q;
    assign err_cfg_o   = err_cfg_q;

endmodule
